// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: per-register busy scoreboard plus youngest-stage
// forwarding select for the in-order integer pipeline.
module fwd_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int REG_W      = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int MAX_LAT    = 15,
    parameter int CNT_W      = $clog2(MAX_LAT + 1),
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic [NUM_SRC*REG_W-1:0]    issue_src,
    input  logic [NUM_SRC-1:0]          issue_src_en,
    input  logic                        issue_rd_we,
    input  logic [REG_W-1:0]            issue_rd,
    input  logic [CNT_W-1:0]            issue_lat,
    input  logic                        done_valid,
    input  logic [REG_W-1:0]            done_rd,
    input  logic                        flush,
    input  logic [FWD_STAGES-1:0]       stage_we,
    input  logic [FWD_STAGES*REG_W-1:0] stage_rd,
    output logic                        stall,
    output logic                        issue_fire,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic [NUM_REGS-1:0]         busy_vec
);

    logic [NUM_REGS-1:0] w_busy;
    logic                w_src_haz;
    logic                w_rd_haz;
    logic                w_stall;
    logic                w_fire;
    logic [31:0]         w_lat_ext;
    logic [CNT_W-1:0]    w_lat_sat;
    logic [REG_W-1:0]    w_hsrc;
    logic [REG_W-1:0]    w_fsrc;

    assign w_lat_ext = 32'(issue_lat);
    assign w_lat_sat = (w_lat_ext > 32'(MAX_LAT)) ?
                       CNT_W'(MAX_LAT) : issue_lat;

    // Source read-after-write hazards against the busy bits.
    always_comb begin
        w_src_haz = 1'b0;
        w_hsrc    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_hsrc = issue_src[k*REG_W +: REG_W];
            if (issue_src_en[k] && w_busy[w_hsrc] && (w_hsrc != '0))
                w_src_haz = 1'b1;
        end
    end

    assign w_rd_haz = issue_rd_we && w_busy[issue_rd] &&
                      (issue_rd != '0);
    assign w_stall  = issue_valid && (w_src_haz || w_rd_haz || flush);
    assign w_fire   = issue_valid && !w_stall;

    // Youngest matching stage wins: scan oldest to youngest, last hit sticks.
    always_comb begin
        fwd_sel = '0;
        w_fsrc  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_fsrc = issue_src[k*REG_W +: REG_W];
            for (int j = FWD_STAGES; j >= 1; j--) begin
                if (stage_we[j-1] && (w_fsrc != '0) &&
                    (stage_rd[(j-1)*REG_W +: REG_W] == w_fsrc))
                    fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(j);
            end
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign w_busy[r] = 1'b0;
        end else begin : g_ent
            logic             r_b;
            logic             r_v;
            logic [CNT_W-1:0] r_c;
            logic             w_set;
            logic             w_done;

            assign w_set  = w_fire && issue_rd_we &&
                            (issue_rd == REG_W'(r));
            assign w_done = done_valid && (done_rd == REG_W'(r));
            assign w_busy[r] = r_b;

            // Entry update: a new issue outranks countdown and done.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_b <= 1'b0;
                    r_v <= 1'b0;
                    r_c <= '0;
                end else if (flush) begin
                    r_b <= 1'b0;
                    r_v <= 1'b0;
                    r_c <= '0;
                end else if (w_set) begin
                    r_b <= 1'b1;
                    r_v <= (issue_lat == '0);
                    r_c <= (issue_lat == '0) ? '0 : w_lat_sat;
                end else if (r_b && !r_v) begin
                    if (r_c > CNT_W'(1)) begin
                        r_c <= r_c - CNT_W'(1);
                    end else begin
                        r_b <= 1'b0;
                        r_c <= '0;
                    end
                end else if (r_b && r_v && w_done) begin
                    r_b <= 1'b0;
                    r_v <= 1'b0;
                end
            end
        end
    end

    assign stall      = w_stall;
    assign issue_fire = w_fire;
    assign busy_vec   = w_busy;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed vectors for the hazard/forwarding unit.
module tb_fwd_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [9:0]  issue_src;
    logic [1:0]  issue_src_en;
    logic        issue_rd_we;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_lat;
    logic        done_valid;
    logic [4:0]  done_rd;
    logic        flush;
    logic [1:0]  stage_we;
    logic [9:0]  stage_rd;
    logic        stall;
    logic        issue_fire;
    logic [3:0]  fwd_sel;
    logic [31:0] busy_vec;

    int vectors;
    int miscompares;

    fwd_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_src    (issue_src),
        .issue_src_en (issue_src_en),
        .issue_rd_we  (issue_rd_we),
        .issue_rd     (issue_rd),
        .issue_lat    (issue_lat),
        .done_valid   (done_valid),
        .done_rd      (done_rd),
        .flush        (flush),
        .stage_we     (stage_we),
        .stage_rd     (stage_rd),
        .stall        (stall),
        .issue_fire   (issue_fire),
        .fwd_sel      (fwd_sel),
        .busy_vec     (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s0,
                         input logic [4:0] s1, input logic [1:0] en,
                         input logic we, input logic [4:0] rd,
                         input logic [3:0] lat);
        issue_valid  = v;
        issue_src    = {s1, s0};
        issue_src_en = en;
        issue_rd_we  = we;
        issue_rd     = rd;
        issue_lat    = lat;
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        done_valid   = 1'b0;
        done_rd      = '0;
        flush        = 1'b0;
        stage_we     = '0;
        stage_rd     = '0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // reset state
        cyc();
        chk("rst_busy", busy_vec, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_fire", {31'b0, issue_fire}, 0);
        flush = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("rst_flush_stall", {31'b0, stall}, 1);
        chk("rst_flush_fire", {31'b0, issue_fire}, 0);
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc();

        // async reset mid-count
        drive(1, 0, 0, 2'b00, 1, 5, 3);
        chk("r5_fire", {31'b0, issue_fire}, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r5_busy", busy_vec, 32'h20);
        cyc();
        chk("r5_busy2", busy_vec, 32'h20);
        reset = 1'b1;
        #1;
        chk("r5_async_clr", busy_vec, 0);
        reset = 1'b0;
        drive(1, 5, 0, 2'b01, 0, 0, 0);
        chk("r5_reader_fire", {31'b0, issue_fire}, 1);
        cyc();

        // fixed latency L=2 with stage-1 forward
        drive(1, 0, 0, 2'b00, 1, 8, 2);
        chk("r8_fire", {31'b0, issue_fire}, 1);
        cyc();
        drive(1, 8, 0, 2'b01, 0, 0, 0);
        chk("r8_stall1", {31'b0, stall}, 1);
        cyc();
        chk("r8_stall2", {31'b0, stall}, 1);
        cyc();
        stage_we = 2'b01;
        stage_rd = {5'd0, 5'd8};
        #1;
        chk("r8_fire_dep", {31'b0, issue_fire}, 1);
        chk("r8_fwd", {28'b0, fwd_sel}, 32'h1);
        cyc();

        // forwarding priority
        drive(0, 3, 0, 2'b01, 0, 0, 0);
        stage_we = 2'b11;
        stage_rd = {5'd3, 5'd3};
        #1;
        chk("fwd_both_r3", {28'b0, fwd_sel}, 32'h1);
        stage_we = 2'b10;
        #1;
        chk("fwd_wb_only", {28'b0, fwd_sel}, 32'h2);
        stage_we = 2'b11;
        stage_rd = {5'd7, 5'd3};
        drive(0, 7, 3, 2'b11, 0, 0, 0);
        chk("fwd_cross", {28'b0, fwd_sel}, 32'h6);
        stage_rd = {5'd0, 5'd0};
        drive(0, 0, 0, 2'b11, 0, 0, 0);
        chk("fwd_r0", {28'b0, fwd_sel}, 32'h0);
        stage_we = '0;
        stage_rd = '0;

        // variable latency divide
        drive(1, 0, 0, 2'b00, 1, 10, 0);
        chk("div_fire", {31'b0, issue_fire}, 1);
        cyc();
        drive(1, 10, 0, 2'b01, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            done_valid = (i == 10);
            done_rd    = 5'd9;
            #1;
            chk("div_stall", {31'b0, stall}, 1);
            cyc();
        end
        chk("div_busy", busy_vec, 32'h400);
        done_valid = 1'b1;
        done_rd    = 5'd10;
        #1;
        chk("div_done_stall", {31'b0, stall}, 1);
        cyc();
        done_valid = 1'b0;
        #1;
        chk("div_dep_fire", {31'b0, issue_fire}, 1);
        chk("div_clr", busy_vec, 0);
        cyc();

        // WAW guard
        drive(1, 0, 0, 2'b00, 1, 4, 4);
        chk("waw_first", {31'b0, issue_fire}, 1);
        cyc();
        drive(1, 0, 0, 2'b00, 1, 4, 1);
        for (int i = 0; i < 4; i++) begin
            chk("waw_stall", {31'b0, stall}, 1);
            cyc();
        end
        chk("waw_fire", {31'b0, issue_fire}, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("waw_l1_busy", busy_vec, 32'h10);
        cyc();
        chk("waw_l1_clr", busy_vec, 0);

        // flush
        drive(1, 0, 0, 2'b00, 1, 6, 5);
        chk("r6_fire", {31'b0, issue_fire}, 1);
        cyc();
        chk("r6_busy", busy_vec, 32'h40);
        flush = 1'b1;
        drive(1, 0, 0, 2'b00, 1, 7, 2);
        chk("flush_stall", {31'b0, stall}, 1);
        chk("flush_nofire", {31'b0, issue_fire}, 0);
        cyc();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("flush_clr", busy_vec, 0);

        // latency 31 truncates to the 4-bit port value 15 = MAX_LAT
        drive(1, 0, 0, 2'b00, 1, 9, 4'(31));
        chk("sat_fire", {31'b0, issue_fire}, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            chk("sat_busy", busy_vec, 32'h200);
            cyc();
        end
        chk("sat_last", busy_vec, 32'h200);
        cyc();
        chk("sat_clr", busy_vec, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
